pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage RV32I core.
- Decides every cycle whether each pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) captures, holds or takes a bubble.
- Handles load-use stalls, taken-branch flushes and multi-cycle data-memory waits, with a timeout watchdog.
- Drives operand-forwarding selects for the EX stage and keeps a saturating stall-cycle counter.

Parameters:
- MAX_WAIT, 16: maximum consecutive cycles in MEM_WAIT before the watchdog trips.
- CNT_W, 16: width of the stall counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- id_rs1  in  5  rs1 of the instruction in ID.
- id_rs2  in  5  rs2 of the instruction in ID.
- ex_rs1  in  5  rs1 of the instruction in EX.
- ex_rs2  in  5  rs2 of the instruction in EX.
- ex_rd  in  5  destination register in EX.
- ex_we  in  1  EX instruction writes the register file.
- ex_is_load  in  1  EX instruction is a load.
- mem_rd  in  5  destination register in MEM.
- mem_we  in  1  MEM instruction writes the register file.
- wb_rd  in  5  destination register in WB.
- wb_we  in  1  WB instruction writes the register file.
- branch_taken  in  1  branch/jump resolved taken in EX.
- dmem_req  in  1  MEM stage has a data-memory access in flight.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC update enable.
- ifid_en  out  1  IF/ID capture enable.
- ifid_flush  out  1  IF/ID bubble.
- idex_en  out  1  ID/EX capture enable.
- idex_flush  out  1  ID/EX bubble.
- exmem_en  out  1  EX/MEM capture enable.
- memwb_en  out  1  MEM/WB capture enable.
- fwd_a  out  2  EX operand A select: 00 register file, 01 EX/MEM, 10 MEM/WB.
- fwd_b  out  2  EX operand B select; same encoding as fwd_a.
- timeout_err  out  1  sticky watchdog error.
- stall_cnt  out  CNT_W  saturating count of cycles with pc_en=0.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Registered state: fsm, wait_cnt, timeout_err, stall_cnt. All control outputs are combinational decodes of state and inputs. They are valid within the cycle, before the pipeline registers capture.
- While rst=1: all *_en=0, ifid_flush=1, idex_flush=1, fwd_a=fwd_b=00.
- At the first edge with rst=1: fsm=RUN, wait_cnt=0, timeout_err=0, stall_cnt=0.
- rst overrides any state, including mid-wait and TIMEOUT.
- FSM states:
  - RUN:
    - dmem_req=1 and dmem_ready=0: freeze this cycle (all *_en=0, no flush) and go to MEM_WAIT; wait_cnt<=1.
    - Otherwise stay in RUN.
  - MEM_WAIT:
    - Freeze all registers every cycle.
    - dmem_ready=1: go to RUN; wait_cnt<=0. In this cycle all enables are 1 and normal RUN decode applies.
    - Else if wait_cnt==MAX_WAIT: go to TIMEOUT.
    - Else wait_cnt<=wait_cnt+1.
  - TIMEOUT: timeout_err=1, all *_en=0. Left only via rst.
- RUN decode, highest priority first:
  - Memory freeze, as above.
  - branch_taken=1: ifid_flush=1, idex_flush=1, all enables=1. Wrong-path fetches are squashed and the PC loads the target.
  - Load-use hazard: ex_is_load & ex_we & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2). Then pc_en=0, ifid_en=0, idex_flush=1, exmem_en=memwb_en=1. This gives exactly a one-cycle bubble; the next cycle the load sits in MEM and the hazard clears.
  - Otherwise all enables=1, no flush.
- A branch that coincides with a freeze is not lost. EX is held, so branch_taken is re-presented and acted on once the freeze releases.
- Forwarding (fwd_a uses ex_rs1, fwd_b uses ex_rs2):
  - 01 if mem_we & mem_rd!=0 & mem_rd==rs.
  - Else 10 if wb_we & wb_rd!=0 & wb_rd==rs.
  - Else 00.
  - Register x0 is never forwarded. EX/MEM beats MEM/WB.
- stall_cnt increments on each cycle with pc_en=0 and rst=0, and saturates at all-ones.

Decomposition:
- Shared package pipe_pkg holds:
  - FSM state typedef: RUN=2'd0, MEM_WAIT=2'd1, TIMEOUT=2'd2.
  - Forwarding encodings: FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10.
  - REG_ZERO constant.
- One natural sub-module, fwd_unit: purely combinational, instantiated once. The FSM and counters stay in the top module.

Test Plan:
- Reset: hold rst=1 for 2 cycles with branch_taken=1 and dmem_req=1 → all enables 0, both flushes 1, stall_cnt=0, fsm=RUN after release.
- Load-use: ex_is_load=1, ex_we=1, ex_rd=5, id_rs2=5 → exactly one cycle of pc_en=0, ifid_en=0, idex_flush=1. With ex_rd=0, no stall.
- Branch: branch_taken=1 for one cycle in RUN → ifid_flush=1, idex_flush=1, all enables 1. The next cycle is clean.
- Memory wait: dmem_req=1, dmem_ready low for 3 cycles then high → enables 0 for 3 cycles, then 1 in the ready cycle; stall_cnt +=3.
- Forward priority: ex_rs1=7, mem_rd=7/mem_we=1, wb_rd=7/wb_we=1 → fwd_a=01. Drop mem_we → 10. With ex_rs1=0, both writers =0 → 00.
- Watchdog: MAX_WAIT=4, dmem_ready held 0 → timeout_err=1 from the 6th frozen cycle onward, pipeline stays frozen. Pulsing rst clears it.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_pkg
//  Purpose  : Shared types, encodings and helpers for the pipeline hazard
//             controller of the 5-stage RV32I core.
//  Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  // Sequencer state encoding
  typedef logic [1:0] state_t;
  localparam state_t RUN      = 2'd0;
  localparam state_t MEM_WAIT = 2'd1;
  localparam state_t TIMEOUT  = 2'd2;

  // EX operand source selects
  typedef logic [1:0] fwd_t;
  localparam fwd_t FWD_RF    = 2'b00;
  localparam fwd_t FWD_EXMEM = 2'b01;
  localparam fwd_t FWD_MEMWB = 2'b10;

  // Architectural zero register; never a forwarding or hazard source
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Operand source for one EX register: the youngest in-flight writer wins
  function automatic fwd_t fwd_sel(input logic [4:0] rs,
                                   input logic [4:0] mem_rd, input logic mem_we,
                                   input logic [4:0] wb_rd,  input logic wb_we);
    fwd_t sel;
    sel = FWD_RF;
    if (mem_we && (mem_rd != REG_ZERO) && (mem_rd == rs)) begin
      sel = FWD_EXMEM;
    end else if (wb_we && (wb_rd != REG_ZERO) && (wb_rd == rs)) begin
      sel = FWD_MEMWB;
    end
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl_if
//  Purpose  : Pipeline-side status in, stage enables / flushes / forwarding
//             selects out, bundled between the datapath and the sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  // Pipeline status toward the controller
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic [4:0]       ex_rs1;
  logic [4:0]       ex_rs2;
  logic [4:0]       ex_rd;
  logic             ex_we;
  logic             ex_is_load;
  logic [4:0]       mem_rd;
  logic             mem_we;
  logic [4:0]       wb_rd;
  logic             wb_we;
  logic             branch_taken;
  logic             dmem_req;
  logic             dmem_ready;
  // Controller decisions toward the pipeline
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_en;
  logic             memwb_en;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             timeout_err;
  logic [CNT_W-1:0] stall_cnt;

  // Datapath side
  modport master (
    output id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, ex_we, ex_is_load,
           mem_rd, mem_we, wb_rd, wb_we, branch_taken, dmem_req, dmem_ready,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           memwb_en, fwd_a, fwd_b, timeout_err, stall_cnt
  );

  // Controller side
  modport slave (
    input  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, ex_we, ex_is_load,
           mem_rd, mem_we, wb_rd, wb_we, branch_taken, dmem_req, dmem_ready,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           memwb_en, fwd_a, fwd_b, timeout_err, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_unit
//  Purpose  : Combinational EX-stage operand forwarding selects.
//  Revision : 1.0 - initial release
// ============================================================================
module fwd_unit
  import pipe_pkg::*;
(
  input  logic [4:0] ex_rs1,
  input  logic [4:0] ex_rs2,
  input  logic [4:0] mem_rd,
  input  logic       mem_we,
  input  logic [4:0] wb_rd,
  input  logic       wb_we,
  output fwd_t       fwd_a,
  output fwd_t       fwd_b
);

  // Each operand independently picks EX/MEM, then MEM/WB, then the register file
  always_comb begin
    fwd_a = fwd_sel(ex_rs1, mem_rd, mem_we, wb_rd, wb_we);
    fwd_b = fwd_sel(ex_rs2, mem_rd, mem_we, wb_rd, wb_we);
  end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl
//  Purpose  : Central pipeline sequencer: stage enables/bubbles for load-use,
//             taken branches and data-memory waits, watchdog, stall counter
//             and EX operand forwarding.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam int WCW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  state_t           fsm_q,         fsm_d;
  logic [WCW-1:0]   wait_cnt_q,    wait_cnt_d;
  logic             timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0] stall_cnt_q,   stall_cnt_d;

  logic w_load_use;
  logic w_freeze;
  logic w_pc_en, w_ifid_en, w_ifid_flush, w_idex_en, w_idex_flush;
  logic w_exmem_en, w_memwb_en;
  fwd_t w_fwd_a, w_fwd_b;

  fwd_unit u_fwd (
    .ex_rs1 (bus.ex_rs1),
    .ex_rs2 (bus.ex_rs2),
    .mem_rd (bus.mem_rd),
    .mem_we (bus.mem_we),
    .wb_rd  (bus.wb_rd),
    .wb_we  (bus.wb_we),
    .fwd_a  (w_fwd_a),
    .fwd_b  (w_fwd_b)
  );

  // Hazard and freeze detection; a MEM_WAIT cycle with ready decodes as RUN
  always_comb begin
    w_load_use = bus.ex_is_load && bus.ex_we && (bus.ex_rd != REG_ZERO) &&
                 ((bus.ex_rd == bus.id_rs1) || (bus.ex_rd == bus.id_rs2));
    w_freeze   = ((fsm_q == RUN)      && bus.dmem_req && !bus.dmem_ready) ||
                 ((fsm_q == MEM_WAIT) && !bus.dmem_ready) ||
                 (fsm_q == TIMEOUT);
  end

  // Stage enable / bubble decode, highest priority first
  always_comb begin
    w_pc_en      = 1'b1;
    w_ifid_en    = 1'b1;
    w_ifid_flush = 1'b0;
    w_idex_en    = 1'b1;
    w_idex_flush = 1'b0;
    w_exmem_en   = 1'b1;
    w_memwb_en   = 1'b1;
    if (rst) begin
      {w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en} = 5'b0;
      w_ifid_flush = 1'b1;
      w_idex_flush = 1'b1;
    end else if (w_freeze) begin
      {w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en} = 5'b0;
    end else if (bus.branch_taken) begin
      w_ifid_flush = 1'b1;
      w_idex_flush = 1'b1;
    end else if (w_load_use) begin
      // Hold PC and IF/ID, push a bubble into ID/EX, let the load advance
      w_pc_en      = 1'b0;
      w_ifid_en    = 1'b0;
      w_idex_flush = 1'b1;
    end
  end

  // Next-state for sequencer, watchdog and saturating stall counter
  always_comb begin
    fsm_d         = fsm_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q;
    stall_cnt_d   = stall_cnt_q;
    case (fsm_q)
      RUN: begin
        if (bus.dmem_req && !bus.dmem_ready) begin
          fsm_d      = MEM_WAIT;
          wait_cnt_d = WCW'(1);
        end
      end
      MEM_WAIT: begin
        if (bus.dmem_ready) begin
          fsm_d      = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WCW'(MAX_WAIT)) begin
          fsm_d         = TIMEOUT;
          timeout_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end
      TIMEOUT: begin
        timeout_err_d = 1'b1;
      end
      default: begin
        fsm_d      = RUN;
        wait_cnt_d = '0;
      end
    endcase
    if (!w_pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset overrides every state including TIMEOUT
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q         <= RUN;
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      fsm_q         <= fsm_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign bus.pc_en       = w_pc_en;
  assign bus.ifid_en     = w_ifid_en;
  assign bus.ifid_flush  = w_ifid_flush;
  assign bus.idex_en     = w_idex_en;
  assign bus.idex_flush  = w_idex_flush;
  assign bus.exmem_en    = w_exmem_en;
  assign bus.memwb_en    = w_memwb_en;
  assign bus.fwd_a       = rst ? FWD_RF : w_fwd_a;
  assign bus.fwd_b       = rst ? FWD_RF : w_fwd_b;
  assign bus.timeout_err = timeout_err_q;
  assign bus.stall_cnt   = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_hazard_ctrl
//  Purpose  : Scoreboard bench for pipe_hazard_ctrl: directed scenarios then
//             random traffic against a cycle-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  localparam int MW = 4;
  localparam int CW = 5;

  typedef struct packed {
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd;
    logic       ex_we, ex_is_load;
    logic [4:0] mem_rd;
    logic       mem_we;
    logic [4:0] wb_rd;
    logic       wb_we, branch_taken, dmem_req, dmem_ready;
  } stim_t;

  typedef struct packed {
    logic          pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en;
    logic [1:0]    fwd_a, fwd_b;
    logic          timeout_err;
    logic [CW-1:0] stall_cnt;
  } obs_t;

  typedef struct packed {
    obs_t o;
    logic regs_known;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(CW)) bus ();

  pipe_hazard_ctrl #(.MAX_WAIT(MW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t q[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   cycle      = 0;

  // Reference model: abstract pipeline status
  bit m_known     = 1'b0;
  bit m_timed_out = 1'b0;
  int m_streak    = 0;   // consecutive memory-frozen cycles so far
  int m_stalls    = 0;

  function automatic logic [1:0] pick(input logic [4:0] rs, input stim_t s);
    if (s.mem_we && s.mem_rd != 0 && s.mem_rd == rs) return 2'b01;
    if (s.wb_we && s.wb_rd != 0 && s.wb_rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  function automatic obs_t model_out(input stim_t s);
    obs_t o;
    bit   frozen;
    bit   hazard;
    o.timeout_err = m_timed_out;
    o.stall_cnt   = CW'(m_stalls);
    o.fwd_a = pick(s.ex_rs1, s);
    o.fwd_b = pick(s.ex_rs2, s);
    {o.pc_en, o.ifid_en, o.idex_en, o.exmem_en, o.memwb_en} = 5'b11111;
    o.ifid_flush = 1'b0;
    o.idex_flush = 1'b0;
    frozen = (m_streak > 0) ? !s.dmem_ready : (s.dmem_req && !s.dmem_ready);
    hazard = s.ex_is_load && s.ex_we && s.ex_rd != 0 &&
             (s.ex_rd == s.id_rs1 || s.ex_rd == s.id_rs2);
    if (s.rst) begin
      {o.pc_en, o.ifid_en, o.idex_en, o.exmem_en, o.memwb_en} = 5'b0;
      o.ifid_flush = 1'b1;
      o.idex_flush = 1'b1;
      o.fwd_a = 2'b00;
      o.fwd_b = 2'b00;
    end else if (m_timed_out || frozen) begin
      {o.pc_en, o.ifid_en, o.idex_en, o.exmem_en, o.memwb_en} = 5'b0;
    end else if (s.branch_taken) begin
      o.ifid_flush = 1'b1;
      o.idex_flush = 1'b1;
    end else if (hazard) begin
      o.pc_en      = 1'b0;
      o.ifid_en    = 1'b0;
      o.idex_flush = 1'b1;
    end
    return o;
  endfunction

  task automatic model_step(input stim_t s, input logic pc_en);
    if (s.rst) begin
      m_known = 1'b1; m_timed_out = 1'b0; m_streak = 0; m_stalls = 0;
    end else begin
      if (!pc_en && m_stalls < (1 << CW) - 1) m_stalls++;
      if (!m_timed_out) begin
        if (m_streak > 0) begin
          if (s.dmem_ready) m_streak = 0;
          else begin
            m_streak++;
            if (m_streak == MW + 1) m_timed_out = 1'b1;
          end
        end else if (s.dmem_req && !s.dmem_ready) begin
          m_streak = 1;
        end
      end
    end
  endtask

  // Drive one cycle of stimulus, record its expectation, advance the model
  task automatic step(input stim_t s);
    exp_t e;
    rst              = s.rst;
    bus.id_rs1       = s.id_rs1;
    bus.id_rs2       = s.id_rs2;
    bus.ex_rs1       = s.ex_rs1;
    bus.ex_rs2       = s.ex_rs2;
    bus.ex_rd        = s.ex_rd;
    bus.ex_we        = s.ex_we;
    bus.ex_is_load   = s.ex_is_load;
    bus.mem_rd       = s.mem_rd;
    bus.mem_we       = s.mem_we;
    bus.wb_rd        = s.wb_rd;
    bus.wb_we        = s.wb_we;
    bus.branch_taken = s.branch_taken;
    bus.dmem_req     = s.dmem_req;
    bus.dmem_ready   = s.dmem_ready;
    e.o          = model_out(s);
    e.regs_known = m_known;
    q.push_back(e);
    model_step(s, e.o.pc_en);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare DUT outputs against the oldest expectation each cycle
  initial begin
    exp_t e;
    obs_t act;
    obs_t mask;
    forever begin
      @(negedge clk);
      cycle++;
      if (q.size() > 0) begin
        e = q.pop_front();
        act = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en, bus.idex_flush,
               bus.exmem_en, bus.memwb_en, bus.fwd_a, bus.fwd_b,
               bus.timeout_err, bus.stall_cnt};
        mask = '1;
        if (!e.regs_known) begin
          mask.timeout_err = 1'b0;
          mask.stall_cnt   = '0;
        end
        vectors++;
        if ((act & mask) !== (e.o & mask)) begin
          miscompares++;
          $display("FAIL outputs cycle %0d: got %h expected %h (pc,ifid,ifidfl,idex,idexfl,exmem,memwb,fa,fb,to,cnt)",
                   cycle, act, e.o);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    stim_t s;
    stim_t z;
    z = '0;
    s = z; s.rst = 1'b1; s.branch_taken = 1'b1; s.dmem_req = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    // Reset with competing branch and memory request
    step(s); step(s);
    step(z);
    // Load-use: one bubble, then the load sits in MEM
    s = z; s.ex_is_load = 1; s.ex_we = 1; s.ex_rd = 5; s.id_rs2 = 5; step(s);
    s = z; s.mem_rd = 5; s.mem_we = 1; s.id_rs2 = 5; step(s);
    s = z; s.ex_is_load = 1; s.ex_we = 1; s.ex_rd = 0; s.id_rs1 = 0; step(s);
    // Taken branch then a clean cycle
    s = z; s.branch_taken = 1; step(s);
    step(z);
    // Memory wait of three cycles
    s = z; s.dmem_req = 1;
    repeat (3) step(s);
    s.dmem_ready = 1; step(s);
    step(z);
    // Forwarding priority
    s = z; s.ex_rs1 = 7; s.ex_rs2 = 7; s.mem_rd = 7; s.mem_we = 1; s.wb_rd = 7; s.wb_we = 1; step(s);
    s.mem_we = 0; step(s);
    s = z; s.mem_we = 1; s.wb_we = 1; step(s);
    s = z; s.ex_rs2 = 9; s.wb_rd = 9; s.wb_we = 1; s.mem_rd = 3; s.mem_we = 1; step(s);
    // Watchdog trip, held, then cleared by reset
    s = z; s.dmem_req = 1;
    repeat (9) step(s);
    s = z; s.rst = 1; step(s);
    step(z);
    // Sustained load-use stall drives the counter into saturation
    s = z; s.ex_is_load = 1; s.ex_we = 1; s.ex_rd = 5; s.id_rs1 = 5;
    repeat (40) step(s);
    step(z);
    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      s.rst          = ($urandom_range(0, 99) < 2);
      s.id_rs1       = 5'($urandom_range(0, 3));
      s.id_rs2       = 5'($urandom_range(0, 3));
      s.ex_rs1       = 5'($urandom_range(0, 3));
      s.ex_rs2       = 5'($urandom_range(0, 3));
      s.ex_rd        = 5'($urandom_range(0, 3));
      s.ex_we        = 1'($urandom_range(0, 1));
      s.ex_is_load   = ($urandom_range(0, 9) < 3);
      s.mem_rd       = 5'($urandom_range(0, 3));
      s.mem_we       = 1'($urandom_range(0, 1));
      s.wb_rd        = 5'($urandom_range(0, 3));
      s.wb_we        = 1'($urandom_range(0, 1));
      s.branch_taken = ($urandom_range(0, 9) == 0);
      s.dmem_req     = ($urandom_range(0, 99) < 15);
      s.dmem_ready   = 1'($urandom_range(0, 1));
      step(s);
    end
    step(z);
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
